fastica_error: RTL and testbench

FASTICA_ERROR -- requirements
Module: fastica_error

---
 rtl/fastica_error_pkg.sv | 18 +
 rtl/fastica_error_if.sv | 14 +
 rtl/fastica_error_row_err.sv | 82 ++++++++
 rtl/fastica_error.sv | 138 +++++++++++++
 tb/tb_fastica_error.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fastica_error_pkg.sv
// Shared FastICA definitions: FSM encoding, the fixed-point unit constant
// and the default convergence settings.
package fastica_error_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // 1.0 in Q2.14
    localparam logic signed [15:0] ONE              = 16'sh4000;
    localparam logic        [15:0] TOL_DEFAULT      = 16'd16;
    localparam logic        [7:0]  MAX_ITER_DEFAULT = 8'd200;

endpackage

// File: rtl/fastica_error_if.sv
// Read bus shared by the new-W and old-W memories: one address, two data
// words returned one cycle later.
interface fastica_error_if
    import fastica_error_pkg::*;
#(
    parameter int DATA_W = 16
);
    logic        [3:0]        w_addr;
    logic signed [DATA_W-1:0] w_new_data;
    logic signed [DATA_W-1:0] w_old_data;

    modport master (output w_addr, input w_new_data, input w_old_data);
    modport slave  (input w_addr, output w_new_data, output w_old_data);
endinterface

// File: rtl/fastica_error_row_err.sv
// Row dot-product of W_new and W_old with per-row error |1 - |dot|| and a
// running maximum over all rows of one evaluation.
module fastica_row_err
    import fastica_error_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC   = 14
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_vld,
    input  logic                     i_row_start,
    input  logic                     i_row_end,
    input  logic signed [DATA_W-1:0] i_new,
    input  logic signed [DATA_W-1:0] i_old,
    output logic        [DATA_W-1:0] o_max_err
);
    localparam int P_W   = 2 * DATA_W;
    localparam int ACC_W = 2 * DATA_W + 2;
    localparam int E_W   = DATA_W + 2;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
    localparam logic signed [E_W-1:0]   ONE_E   = E_W'(ONE);

    logic signed [ACC_W-1:0]  r_acc;
    logic        [DATA_W-1:0] r_max;

    logic signed [P_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_shift;
    logic signed [DATA_W-1:0] w_dot;
    logic signed [E_W-1:0]    w_dot_ext;
    logic signed [E_W-1:0]    w_abs;
    logic signed [E_W-1:0]    w_diff;
    logic        [E_W-1:0]    w_err;

    assign w_prod     = i_new * i_old;
    assign w_prod_ext = {{(ACC_W - P_W){w_prod[P_W-1]}}, w_prod};
    // the first product of a row replaces the accumulator instead of adding
    assign w_acc_sum  = (i_row_start ? '0 : r_acc) + w_prod_ext;
    assign w_shift    = w_acc_sum >>> FRAC;

    // saturate the Q-aligned dot product into the element width
    always_comb begin
        w_dot = w_shift[DATA_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_dot = SAT_MAX[DATA_W-1:0];
        end else if (w_shift < SAT_MIN) begin
            w_dot = SAT_MIN[DATA_W-1:0];
        end
    end

    // two guard bits so |-32768| and 1.0 - |dot| never overflow;
    // abs(dot) makes a sign-flipped row count as converged
    assign w_dot_ext = {{2{w_dot[DATA_W-1]}}, w_dot};
    assign w_abs     = (w_dot_ext < 0) ? -w_dot_ext : w_dot_ext;
    assign w_diff    = ONE_E - w_abs;
    assign w_err     = (w_diff < 0) ? E_W'(-w_diff) : E_W'(w_diff);

    // accumulate each valid word and fold the row error into the maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_max <= '0;
        end else begin
            if (i_clr) begin
                r_max <= '0;
            end
            if (i_vld) begin
                r_acc <= w_acc_sum;
                if (i_row_end && (w_err > {2'b00, r_max})) begin
                    r_max <= w_err[DATA_W-1:0];
                end
            end
        end
    end

    assign o_max_err = r_max;

endmodule

// File: rtl/fastica_error.sv
// FastICA convergence check: streams W_new/W_old element pairs, measures
// how far each row dot product is from +/-1.0 and decides convergence.
module fastica_error
    import fastica_error_pkg::*;
#(
    parameter int                N_COMP   = 4,
    parameter int                DATA_W   = 16,
    parameter int                FRAC     = 14,
    parameter logic [DATA_W-1:0] TOL      = DATA_W'(TOL_DEFAULT),
    parameter logic [7:0]        MAX_ITER = MAX_ITER_DEFAULT
)(
    input  logic                clk_error,
    input  logic                rstn_error,
    input  logic                en_error,
    input  logic                iter_clr,
    fastica_error_if.master     mem,
    output logic                error_busy,
    output logic                error_done,
    output logic                converged,
    output logic [DATA_W-1:0]   max_err,
    output logic [7:0]          iter_cnt,
    output logic                max_iter_hit
);
    localparam logic [3:0] LAST_ADDR = 4'(N_COMP * N_COMP - 1);
    localparam logic [3:0] COL_LAST  = 4'(N_COMP - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_addr;
    logic [3:0] r_col;
    logic       r_dvld;
    logic [3:0] r_dcol;
    logic       r_busy;
    logic       r_conv;
    logic       r_hit;
    logic [7:0] r_iter;

    logic       w_start;
    logic       w_tol_ok;
    logic       w_limit;
    logic       w_conv_next;

    assign w_start     = (r_state == ST_IDLE) && en_error;
    assign w_tol_ok    = (max_err <= TOL);
    assign w_limit     = ({1'b0, r_iter} + 9'd1) >= {1'b0, MAX_ITER};
    assign w_conv_next = w_tol_ok || w_limit;

    // state register
    always_ff @(posedge clk_error or negedge rstn_error) begin
        if (!rstn_error) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic; en_error only matters in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (en_error) w_state_next = ST_READ;
            ST_READ:  if (r_addr == LAST_ADDR) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // address walk plus a one-cycle-delayed copy that tags returning data
    always_ff @(posedge clk_error or negedge rstn_error) begin
        if (!rstn_error) begin
            r_addr <= '0;
            r_col  <= '0;
            r_dvld <= 1'b0;
            r_dcol <= '0;
        end else begin
            if (w_start) begin
                r_addr <= '0;
                r_col  <= '0;
            end else if ((r_state == ST_READ) && (r_addr != LAST_ADDR)) begin
                r_addr <= r_addr + 4'd1;
                r_col  <= (r_col == COL_LAST) ? 4'd0 : r_col + 4'd1;
            end
            r_dvld <= (r_state == ST_READ);
            r_dcol <= r_col;
        end
    end

    // verdict flags; busy persists after DONE while not converged
    always_ff @(posedge clk_error or negedge rstn_error) begin
        if (!rstn_error) begin
            r_busy <= 1'b0;
            r_conv <= 1'b0;
            r_hit  <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end else if (r_state == ST_CHECK) begin
            r_busy <= ~w_conv_next;
            r_conv <= w_conv_next;
            r_hit  <= w_limit && !w_tol_ok;
        end
    end

    // evaluation counter; a coincident clear beats the increment
    always_ff @(posedge clk_error or negedge rstn_error) begin
        if (!rstn_error) begin
            r_iter <= '0;
        end else if (iter_clr) begin
            r_iter <= '0;
        end else if ((r_state == ST_CHECK) && (r_iter != 8'hFF)) begin
            r_iter <= r_iter + 8'd1;
        end
    end

    fastica_row_err #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_row_err (
        .clk         (clk_error),
        .rst_n       (rstn_error),
        .i_clr       (w_start),
        .i_vld       (r_dvld),
        .i_row_start (r_dcol == 4'd0),
        .i_row_end   (r_dcol == COL_LAST),
        .i_new       (mem.w_new_data),
        .i_old       (mem.w_old_data),
        .o_max_err   (max_err)
    );

    assign mem.w_addr   = r_addr;
    assign error_busy   = r_busy;
    assign error_done   = (r_state == ST_DONE);
    assign converged    = r_conv;
    assign max_iter_hit = r_hit;
    assign iter_cnt     = r_iter;

endmodule

// File: tb/tb_fastica_error.sv
// Bench for fastica_error: W memories modelled with a one-cycle read,
// expected verdicts queued at start and checked when error_done arrives.
module tb_fastica_error;
    import fastica_error_pkg::*;

    typedef struct packed {
        logic [15:0] err;
        logic        conv;
        logic        hit;
        logic [7:0]  iter;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        en;
    logic        clr;
    logic        busy;
    logic        done;
    logic        conv;
    logic [15:0] merr;
    logic [7:0]  iter;
    logic        hit;

    logic signed [15:0] mem_new [0:15];
    logic signed [15:0] mem_old [0:15];

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    fastica_error_if #(.DATA_W(16)) mif ();

    fastica_error dut (
        .clk_error    (clk),
        .rstn_error   (rstn),
        .en_error     (en),
        .iter_clr     (clr),
        .mem          (mif),
        .error_busy   (busy),
        .error_done   (done),
        .converged    (conv),
        .max_err      (merr),
        .iter_cnt     (iter),
        .max_iter_hit (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read memories
    always @(posedge clk) begin
        mif.w_new_data <= mem_new[mif.w_addr];
        mif.w_old_data <= mem_old[mif.w_addr];
    end

    task automatic load_diag(input logic signed [15:0] nd, input logic signed [15:0] od);
        for (int i = 0; i < 16; i++) begin
            mem_new[i] = ((i % 5) == 0) ? nd : 16'sd0;
            mem_old[i] = ((i % 5) == 0) ? od : 16'sd0;
        end
    endtask

    // each W_new row has cos45 on the diagonal and sin45 on the next column
    task automatic load_rot();
        for (int i = 0; i < 16; i++) begin
            mem_new[i] = 16'sd0;
            mem_old[i] = ((i % 5) == 0) ? 16'sh4000 : 16'sd0;
        end
        for (int r = 0; r < 4; r++) begin
            mem_new[r * 4 + r]           = 16'sh2D41;
            mem_new[r * 4 + ((r + 1) % 4)] = 16'sh2D41;
        end
    endtask

    // pulse en for one sampling edge, return cycles until error_done
    task automatic start_eval(output int lat);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        load_diag(16'sh4000, 16'sh4000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mif.w_addr, busy, done, conv, merr, iter, hit} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_state: got addr=%h busy=%b done=%b conv=%b err=%h iter=%0d hit=%b want all 0",
                     mif.w_addr, busy, done, conv, merr, iter, hit);
        end
        $display("reset: addr=%h busy=%b conv=%b iter=%0d", mif.w_addr, busy, conv, iter);
        rstn = 1'b1;
    endtask

    task automatic run_diag(input string nm, input logic signed [15:0] nd, input logic [15:0] e_err,
                            input logic e_conv, input logic [7:0] e_iter);
        int   lat;
        exp_t e;
        load_diag(nd, 16'sh4000);
        sb.push_back('{err: e_err, conv: e_conv, hit: 1'b0, iter: e_iter, busy: ~e_conv});
        start_eval(lat);
        e = sb.pop_front();
        $display("%s: lat=%0d err=%h conv=%b hit=%b iter=%0d busy=%b", nm, lat, merr, conv, hit, iter, busy);
        n_cmp++;
        if (lat !== 19 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want 19", nm, lat);
        end
        n_cmp++;
        if (merr !== e.err) begin
            n_bad++;
            $display("FAIL %s_max_err: got %h want %h", nm, merr, e.err);
        end
        n_cmp++;
        if (conv !== e.conv || hit !== e.hit || busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s_flags: got conv=%b hit=%b busy=%b want conv=%b hit=%b busy=%b",
                     nm, conv, hit, busy, e.conv, e.hit, e.busy);
        end
        n_cmp++;
        if (iter !== e.iter) begin
            n_bad++;
            $display("FAIL %s_iter: got %0d want %0d", nm, iter, e.iter);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== e.busy) begin
            n_bad++;
            $display("FAIL %s_after_done: got done=%b busy=%b want done=0 busy=%b", nm, done, busy, e.busy);
        end
    endtask

    task automatic test_identity();
        run_diag("identity", 16'sh4000, 16'h0000, 1'b1, 8'd1);
    endtask

    task automatic test_neg_identity();
        run_diag("neg_identity", -16'sh4000, 16'h0000, 1'b1, 8'd2);
    endtask

    task automatic test_tolerance();
        run_diag("tol_16", 16'sh3FF0, 16'd16, 1'b1, 8'd4);
        run_diag("tol_17", 16'sh3FEF, 16'd17, 1'b0, 8'd5);
    endtask

    task automatic test_rotation();
        int   lat;
        exp_t e;
        load_rot();
        sb.push_back('{err: 16'h12BF, conv: 1'b0, hit: 1'b0, iter: 8'd3, busy: 1'b1});
        start_eval(lat);
        e = sb.pop_front();
        $display("rotation: lat=%0d err=%h conv=%b iter=%0d busy=%b", lat, merr, conv, iter, busy);
        n_cmp++;
        if (lat !== 19 || merr !== e.err) begin
            n_bad++;
            $display("FAIL rotation_err: got lat=%0d err=%h want lat=19 err=%h", lat, merr, e.err);
        end
        n_cmp++;
        if (conv !== e.conv || iter !== e.iter) begin
            n_bad++;
            $display("FAIL rotation_conv: got conv=%b iter=%0d want conv=%b iter=%0d", conv, iter, e.conv, e.iter);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== e.busy) begin
            n_bad++;
            $display("FAIL rotation_busy: got %b want 1", busy);
        end
    endtask

    // iter_clr arriving in the CHECK cycle must leave the count at 0
    task automatic test_clr_vs_check();
        load_diag(16'sh4000, 16'sh4000);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (17) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        $display("clr_vs_check: done=%b iter=%0d", done, iter);
        n_cmp++;
        if (done !== 1'b1 || iter !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_vs_check: got done=%b iter=%0d want done=1 iter=0", done, iter);
        end
    endtask

    task automatic test_iter_limit();
        int   lat;
        exp_t e;
        load_rot();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int j = 1; j <= 200; j++) begin
            sb.push_back('{err: 16'h12BF, conv: (j == 200), hit: (j == 200), iter: 8'(j), busy: (j != 200)});
            start_eval(lat);
            e = sb.pop_front();
            $display("iter_limit[%0d]: lat=%0d err=%h conv=%b hit=%b iter=%0d", j, lat, merr, conv, hit, iter);
            n_cmp++;
            if (lat !== 19 || conv !== e.conv || hit !== e.hit || iter !== e.iter || merr !== e.err) begin
                n_bad++;
                $display("FAIL iter_limit_%0d: got lat=%0d conv=%b hit=%b iter=%0d err=%h want lat=19 conv=%b hit=%b iter=%0d err=%h",
                         j, lat, conv, hit, iter, merr, e.conv, e.hit, e.iter, e.err);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL iter_limit_busy: got %b want 0", busy);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        $display("iter_clr: iter=%0d", iter);
        n_cmp++;
        if (iter !== 8'd0) begin
            n_bad++;
            $display("FAIL iter_clr: got %0d want 0", iter);
        end
    endtask

    task automatic test_reset_mid();
        load_diag(16'sh4000, 16'sh4000);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || mif.w_addr !== 4'd7) begin
            n_bad++;
            $display("FAIL mid_eval_state: got busy=%b addr=%h want busy=1 addr=7", busy, mif.w_addr);
        end
        #1 rstn = 1'b0;
        #1;
        $display("reset_mid: addr=%h busy=%b conv=%b err=%h iter=%0d", mif.w_addr, busy, conv, merr, iter);
        n_cmp++;
        if ({mif.w_addr, busy, done, conv, merr, iter, hit} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got addr=%h busy=%b done=%b conv=%b err=%h iter=%0d hit=%b want all 0",
                     mif.w_addr, busy, done, conv, merr, iter, hit);
        end
        @(negedge clk);
        rstn = 1'b1;
        run_diag("after_reset", 16'sh4000, 16'h0000, 1'b1, 8'd1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neg_identity();
        test_rotation();
        test_tolerance();
        test_clr_vs_check();
        test_iter_limit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard stop in case the flow above ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
